// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: feeds WIDTH-bit operands through an external 4-bit CLA one nibble per cycle, LSB first
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
  input  logic             sub,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_cin,
  input  logic [3:0]       cla_sum,
  input  logic             cla_cout,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW = $clog2(NIBBLES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                   state;
  logic [NIBBLES-1:0][3:0]  a_reg, b_reg, res_reg;
  logic [IW-1:0]            idx;
  logic                     cin_reg;
  logic                     run;
  assign run       = state == RUN;
  assign cla_a     = run ? a_reg[idx] : 4'd0;
  assign cla_b     = run ? b_reg[idx] : 4'd0;
  assign cla_cin   = run & cin_reg;
  assign busy      = state != IDLE;
  assign res_valid = state == DONE;
  assign result    = res_reg;
  // Sequencer: latch operands, step one nibble per cycle chaining the carry, hold result until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cin_reg   <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_reg   <= op_a;
          b_reg   <= sub ? ~op_b : op_b;
          cin_reg <= sub | carry_in;
          res_reg <= '0;
          idx     <= '0;
          state   <= RUN;
        end
        RUN: begin
          res_reg[idx] <= cla_sum;
          cin_reg      <= cla_cout;
          if (idx == IW'(NIBBLES - 1)) begin
            state     <= DONE;
            carry_out <= cla_cout;
            overflow  <= cla_a[3] ^ cla_b[3] ^ cla_sum[3] ^ cla_cout;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed table plus handshake/reset sequences around a behavioural 4-bit CLA
module tb_nibble_serial_add_ctrl;
  localparam int W = 16;
  logic         clk = 1'b0;
  logic         rst, start, carry_in, sub, res_ready;
  logic [W-1:0] op_a, op_b, result;
  logic [3:0]   cla_a, cla_b, cla_sum;
  logic         cla_cin, cla_cout, busy, res_valid, carry_out, overflow;
  int           total = 0;
  int           bad = 0;

  typedef struct {
    logic [15:0] a, b;
    logic        ci, sb;
    logic [15:0] r;
    logic        co, ov;
    logic [3:0]  cm, b0;
  } vec_t;
  vec_t v[8];

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .carry_in(carry_in), .sub(sub), .cla_a(cla_a), .cla_b(cla_b),
    .cla_cin(cla_cin), .cla_sum(cla_sum), .cla_cout(cla_cout),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  assign {cla_cout, cla_sum} = 5'(cla_a) + 5'(cla_b) + 5'(cla_cin);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb,
                        output int lat, output logic [3:0] cm, output logic [3:0] b0);
    int k;
    op_a = a; op_b = b; carry_in = ci; sub = sb; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1; k = 0; cm = 4'd0; b0 = cla_b;
    while (!res_valid && lat < 20) begin
      if (k < 4) cm[k] = cla_cin;
      k++;
      tick;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [3:0] cm, b0;
    v[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 4'b0000, 4'h1};
    v[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110, 4'h1};
    v[2] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 4'b1111, 4'h1};
    v[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110, 4'h1};
    v[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4'b0001, 4'hE};
    v[5] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4'b0001, 4'h8};
    v[6] = '{16'h0003, 16'h0001, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 4'b1111, 4'hE};
    v[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000, 4'h0};
    rst = 1'b1; start = 1'b0; carry_in = 1'b0; sub = 1'b0; res_ready = 1'b1;
    op_a = '0; op_b = '0;
    tick; tick;
    rst = 1'b0;
    chk("reset busy", 32'(busy), 0);
    chk("reset res_valid", 32'(res_valid), 0);
    chk("reset result", 32'(result), 0);
    chk("reset carry_out", 32'(carry_out), 0);
    chk("reset overflow", 32'(overflow), 0);
    chk("reset cla", {cla_a, cla_b, 3'd0, cla_cin}, 0);

    for (int i = 0; i < 8; i++) begin
      run_op(v[i].a, v[i].b, v[i].ci, v[i].sb, lat, cm, b0);
      chk($sformatf("v%0d latency", i), 32'(lat), 5);
      chk($sformatf("v%0d result", i), 32'(result), 32'(v[i].r));
      chk($sformatf("v%0d carry_out", i), 32'(carry_out), 32'(v[i].co));
      chk($sformatf("v%0d overflow", i), 32'(overflow), 32'(v[i].ov));
      chk($sformatf("v%0d cin mask", i), 32'(cm), 32'(v[i].cm));
      chk($sformatf("v%0d cla_b nib0", i), 32'(b0), 32'(v[i].b0));
      chk($sformatf("v%0d done cla_a", i), 32'(cla_a), 0);
      tick;
      chk($sformatf("v%0d idle busy", i), 32'(busy), 0);
      chk($sformatf("v%0d idle valid", i), 32'(res_valid), 0);
    end

    res_ready = 1'b0;
    op_a = 16'h1234; op_b = 16'h4321; carry_in = 1'b0; sub = 1'b0; start = 1'b1;
    tick;
    op_a = 16'hFFFF; op_b = 16'hFFFF; carry_in = 1'b1; sub = 1'b1;
    lat = 1;
    while (!res_valid && lat < 20) begin
      tick;
      lat++;
    end
    chk("bp latency", 32'(lat), 5);
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("bp%0d valid", c), 32'(res_valid), 1);
      chk($sformatf("bp%0d result", c), 32'(result), 32'h5555);
      chk($sformatf("bp%0d carry_out", c), 32'(carry_out), 0);
      tick;
    end
    res_ready = 1'b1;
    tick;
    chk("bp release busy", 32'(busy), 0);
    chk("bp release valid", 32'(res_valid), 0);
    op_a = 16'h0100; op_b = 16'h0200; carry_in = 1'b0; sub = 1'b0;
    tick;
    start = 1'b0;
    chk("bp next accepted", 32'(busy), 1);
    lat = 1;
    while (!res_valid && lat < 20) begin
      tick;
      lat++;
    end
    chk("bp next result", 32'(result), 32'h0300);
    tick;

    op_a = 16'h1234; op_b = 16'h4321; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    chk("mid-run cla_a idx2", 32'(cla_a), 32'h2);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst busy", 32'(busy), 0);
    chk("rst valid", 32'(res_valid), 0);
    chk("rst result", 32'(result), 0);
    chk("rst cla", {cla_a, cla_b, 3'd0, cla_cin}, 0);
    run_op(16'h0001, 16'h0002, 1'b0, 1'b0, lat, cm, b0);
    chk("post-rst latency", 32'(lat), 5);
    chk("post-rst result", 32'(result), 32'h0003);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
